// File: rtl/seq_detect_pkg.sv
// Shared definitions for the parameterised serial sequence detector.
// State indices, one-hot encodings and default widths.
package seq_detect_pkg;

   localparam int PAT_W_DEF = 4;
   localparam int CNT_W_DEF = 8;

   typedef enum int {
      ST_IDLE = 0,
      ST_FILL = 1,
      ST_HUNT = 2
   } state_e;

   localparam logic [2:0] S_IDLE = 3'b001;
   localparam logic [2:0] S_FILL = 3'b010;
   localparam logic [2:0] S_HUNT = 3'b100;

   function automatic logic is_armed(input logic [2:0] st);
      return st[ST_FILL] | st[ST_HUNT];
   endfunction

endpackage

// File: rtl/seq_detect_if.sv
// Control/data bundle between a stimulus source and the sequence detector.
interface seq_detect_if
   import seq_detect_pkg::*;
#(
   parameter int PAT_W = PAT_W_DEF,
   parameter int CNT_W = CNT_W_DEF
);
   logic             din;
   logic             din_valid;
   logic             start;
   logic             clear;
   logic [PAT_W-1:0] pattern;
   logic             overlap;
   logic             dout;
   logic [CNT_W-1:0] match_cnt;
   logic             armed;

   modport master (
      output din, din_valid, start, clear, pattern, overlap,
      input  dout, match_cnt, armed
   );

   modport slave (
      input  din, din_valid, start, clear, pattern, overlap,
      output dout, match_cnt, armed
   );
endinterface

// File: rtl/seq_window_shift.sv
// PAT_W-bit receive window (MSB = oldest bit) plus a fill counter that
// saturates at PAT_W; o_fill_last means the next shifted bit completes it.
module seq_window_shift
   import seq_detect_pkg::*;
#(
   parameter int PAT_W = PAT_W_DEF
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_clr,
   input  logic             i_restart,
   input  logic             i_shift,
   input  logic             i_din,
   output logic [PAT_W-1:0] o_window_next,
   output logic             o_full,
   output logic             o_fill_last
);
   localparam int FC_W = $clog2(PAT_W + 1);

   logic [PAT_W-1:0] r_window;
   logic [FC_W-1:0]  r_fill;

   assign o_window_next = {r_window[PAT_W-2:0], i_din};
   assign o_full        = (r_fill == FC_W'(PAT_W));
   assign o_fill_last   = (r_fill == FC_W'(PAT_W - 1));

   // Restart zeroes only the fill count so consumed bits cannot be reused.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_window <= {PAT_W{1'b0}};
         r_fill   <= {FC_W{1'b0}};
      end else if (i_clr) begin
         r_window <= {PAT_W{1'b0}};
         r_fill   <= {FC_W{1'b0}};
      end else if (i_shift) begin
         r_window <= o_window_next;
         if (i_restart) begin
            r_fill <= {FC_W{1'b0}};
         end else if (!o_full) begin
            r_fill <= r_fill + FC_W'(1);
         end else begin
            r_fill <= r_fill;
         end
      end else begin
         r_window <= r_window;
         r_fill   <= r_fill;
      end
   end
endmodule

// File: rtl/seq_detect_param.sv
// Serial pattern detector: IDLE/FILL/HUNT one-hot FSM, compare and match counter.
// Define SEQ_DETECT_CNT_EN to build the saturating match counter; otherwise it reads 0.
module seq_detect_param
   import seq_detect_pkg::*;
#(
   parameter int PAT_W = PAT_W_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   seq_detect_if.slave  bus
);
   logic [2:0]       r_state;
   logic [2:0]       w_state_nxt;
   logic [PAT_W-1:0] r_pattern;
   logic             r_overlap;
   logic             r_dout;

   logic [PAT_W-1:0] w_window_next;
   logic             w_full;
   logic             w_fill_last;
   logic             w_armed;
   logic             w_shift;
   logic             w_match;
   logic             w_restart;
   logic             w_win_clr;
   logic             w_load;

   assign w_armed   = is_armed(r_state);
   assign w_shift   = bus.din_valid & w_armed & ~bus.clear;
   // The incoming bit is part of the compare, and only a full window may match.
   assign w_match   = w_shift & (w_full | w_fill_last) & (w_window_next == r_pattern);
   assign w_restart = w_match & ~r_overlap;
   assign w_load    = r_state[ST_IDLE] & bus.start & ~bus.clear;
   assign w_win_clr = bus.clear | w_load;

   seq_window_shift #(.PAT_W(PAT_W)) u_window (
      .i_clk        (i_clk),
      .i_rst_n      (i_rst_n),
      .i_clr        (w_win_clr),
      .i_restart    (w_restart),
      .i_shift      (w_shift),
      .i_din        (bus.din),
      .o_window_next(w_window_next),
      .o_full       (w_full),
      .o_fill_last  (w_fill_last)
   );

   always_comb begin
      w_state_nxt = r_state;
      if (bus.clear) begin
         w_state_nxt = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE: w_state_nxt = bus.start ? S_FILL : S_IDLE;
            S_FILL: w_state_nxt = (w_shift && w_fill_last && !w_restart) ? S_HUNT : S_FILL;
            S_HUNT: w_state_nxt = w_restart ? S_FILL : S_HUNT;
            default: w_state_nxt = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state   <= S_IDLE;
         r_pattern <= {PAT_W{1'b0}};
         r_overlap <= 1'b0;
         r_dout    <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_dout  <= w_match;
         if (w_load) begin
            r_pattern <= bus.pattern;
            r_overlap <= bus.overlap;
         end else begin
            r_pattern <= r_pattern;
            r_overlap <= r_overlap;
         end
      end
   end

   assign bus.dout  = r_dout;
   assign bus.armed = w_armed;

`ifdef SEQ_DETECT_CNT_EN
   logic [CNT_W-1:0] r_cnt;

   // Saturates at all-ones rather than wrapping.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt <= {CNT_W{1'b0}};
      end else if (bus.clear) begin
         r_cnt <= {CNT_W{1'b0}};
      end else if (w_match && (r_cnt != {CNT_W{1'b1}})) begin
         r_cnt <= r_cnt + CNT_W'(1);
      end else begin
         r_cnt <= r_cnt;
      end
   end

   assign bus.match_cnt = r_cnt;
`else
   assign bus.match_cnt = {CNT_W{1'b0}};
`endif
endmodule

// File: tb/tb_seq_detect_param.sv
// Directed bench for seq_detect_param: a PAT_W=4/CNT_W=8 and a PAT_W=2/CNT_W=2 instance.
module tb_seq_detect_param;
   import seq_detect_pkg::*;

`ifdef SEQ_DETECT_CNT_EN
   localparam bit CNT_ON = 1'b1;
`else
   localparam bit CNT_ON = 1'b0;
`endif

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   n_tests = 0;
   int   n_fail  = 0;

   seq_detect_if #(.PAT_W(4), .CNT_W(8)) if4 ();
   seq_detect_if #(.PAT_W(2), .CNT_W(2)) if2 ();

   seq_detect_param #(.PAT_W(4), .CNT_W(8)) u_dut4 (
      .i_clk  (clk),
      .i_rst_n(rst_n),
      .bus    (if4.slave)
   );

   seq_detect_param #(.PAT_W(2), .CNT_W(2)) u_dut2 (
      .i_clk  (clk),
      .i_rst_n(rst_n),
      .bus    (if2.slave)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] cexp(input int n);
      return CNT_ON ? 32'(n) : 32'd0;
   endfunction

   task automatic start4(input logic [3:0] pat, input logic ov);
      if4.pattern = pat;
      if4.overlap = ov;
      if4.start   = 1'b1;
      tick();
      if4.start   = 1'b0;
      chk("start4_armed", 32'(if4.armed), 32'd1);
   endtask

   task automatic clear4();
      if4.din_valid = 1'b0;
      if4.clear     = 1'b1;
      tick();
      if4.clear     = 1'b0;
      chk("clear4_armed", 32'(if4.armed), 32'd0);
      chk("clear4_cnt", 32'(if4.match_cnt), 32'd0);
   endtask

   // Streams 1,0,1,0,1,0 against pattern 1010; exp holds the expected pulse per bit, first bit in [5].
   task automatic run_1010(input logic ov, input logic [5:0] exp);
      logic [5:0] stream;
      int         n;
      stream = 6'b101010;
      n      = 0;
      start4(4'b1010, ov);
      if4.din_valid = 1'b1;
      for (int i = 5; i >= 0; i--) begin
         if4.din = stream[i];
         tick();
         if (exp[i]) n++;
         chk($sformatf("s1010_ov%0d_dout_b%0d", ov, 6 - i), 32'(if4.dout), 32'(exp[i]));
      end
      if4.din_valid = 1'b0;
      chk($sformatf("s1010_ov%0d_cnt", ov), 32'(if4.match_cnt), cexp(n));
      clear4();
   endtask

   initial begin
      logic [3:0] bits_a;
      int         sat_cnt;

      if4.din = 1'b0; if4.din_valid = 1'b0; if4.start = 1'b0; if4.clear = 1'b0;
      if4.pattern = 4'b0000; if4.overlap = 1'b0;
      if2.din = 1'b0; if2.din_valid = 1'b0; if2.start = 1'b0; if2.clear = 1'b0;
      if2.pattern = 2'b00; if2.overlap = 1'b0;

      #1;
      chk("rst_dout4", 32'(if4.dout), 32'd0);
      chk("rst_armed4", 32'(if4.armed), 32'd0);
      chk("rst_cnt4", 32'(if4.match_cnt), 32'd0);
      chk("rst_armed2", 32'(if2.armed), 32'd0);
      tick();
      tick();
      rst_n = 1'b1;
      tick();

      // Pattern 0111, non-overlap; pattern/overlap changes after Start must not matter.
      start4(4'b0111, 1'b0);
      if4.pattern = 4'b1111;
      if4.overlap = 1'b1;
      bits_a = 4'b0111;
      if4.din_valid = 1'b1;
      for (int i = 3; i >= 0; i--) begin
         if4.din = bits_a[i];
         tick();
         chk($sformatf("p0111_dout_b%0d", 4 - i), 32'(if4.dout), (i == 0) ? 32'd1 : 32'd0);
      end
      chk("p0111_cnt", 32'(if4.match_cnt), cexp(1));
      if4.din_valid = 1'b0;
      tick();
      chk("p0111_pulse_width", 32'(if4.dout), 32'd0);
      clear4();

      run_1010(1'b1, 6'b000101);
      run_1010(1'b0, 6'b000100);

      // Gap in Din_valid, with an ignored Start mid-sequence.
      start4(4'b0111, 1'b0);
      if4.din_valid = 1'b1;
      if4.din = 1'b0;
      tick();
      chk("gap_b1", 32'(if4.dout), 32'd0);
      if4.din = 1'b1;
      tick();
      chk("gap_b2", 32'(if4.dout), 32'd0);
      if4.din_valid = 1'b0;
      for (int g = 0; g < 3; g++) begin
         if4.start   = (g == 1);
         if4.pattern = 4'b1111;
         tick();
         chk($sformatf("gap_idle%0d_dout", g), 32'(if4.dout), 32'd0);
      end
      if4.start = 1'b0;
      if4.din_valid = 1'b1;
      if4.din = 1'b1;
      tick();
      chk("gap_b3", 32'(if4.dout), 32'd0);
      tick();
      chk("gap_b4", 32'(if4.dout), 32'd1);
      chk("gap_cnt", 32'(if4.match_cnt), cexp(1));

      // Partial 0,1,1 then asynchronous reset mid-cycle.
      bits_a = 4'b0110;
      for (int i = 3; i >= 1; i--) begin
         if4.din = bits_a[i];
         tick();
         chk($sformatf("rstseq_b%0d", 4 - i), 32'(if4.dout), 32'd0);
      end
      if4.din_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_dout", 32'(if4.dout), 32'd0);
      chk("arst_armed", 32'(if4.armed), 32'd0);
      chk("arst_cnt", 32'(if4.match_cnt), 32'd0);
      tick();
      rst_n = 1'b1;
      if4.din_valid = 1'b1;
      if4.din = 1'b1;
      tick();
      chk("postrst_dout", 32'(if4.dout), 32'd0);
      chk("postrst_armed", 32'(if4.armed), 32'd0);
      tick();
      chk("postrst_dout2", 32'(if4.dout), 32'd0);
      if4.din_valid = 1'b0;

      // PAT_W=2 overlap with a 2-bit saturating counter.
      if2.pattern = 2'b11;
      if2.overlap = 1'b1;
      if2.start   = 1'b1;
      tick();
      if2.start   = 1'b0;
      chk("p11_armed", 32'(if2.armed), 32'd1);
      if2.din_valid = 1'b1;
      if2.din = 1'b1;
      sat_cnt = 0;
      for (int i = 1; i <= 6; i++) begin
         tick();
         if (i >= 2 && sat_cnt < 3) sat_cnt++;
         chk($sformatf("p11_dout_b%0d", i), 32'(if2.dout), (i >= 2) ? 32'd1 : 32'd0);
         chk($sformatf("p11_cnt_b%0d", i), 32'(if2.match_cnt), cexp(sat_cnt));
      end
      if2.clear = 1'b1;
      if2.start = 1'b1;
      tick();
      if2.clear = 1'b0;
      if2.start = 1'b0;
      chk("clrstart_armed", 32'(if2.armed), 32'd0);
      chk("clrstart_cnt", 32'(if2.match_cnt), 32'd0);
      chk("clrstart_dout", 32'(if2.dout), 32'd0);
      tick();
      chk("clrstart_idle_armed", 32'(if2.armed), 32'd0);
      chk("clrstart_idle_dout", 32'(if2.dout), 32'd0);
      if2.din_valid = 1'b0;
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/seq_detect_param.md
SEQ_DETECT_PARAM -- requirements
Module: seq_detect_param

Interface
REQ-001 Parameter PAT_W, default 4: pattern length in bits; legal range 2..16.
REQ-002 Parameter CNT_W, default 8: match-counter width in bits.
REQ-003 Clk  input  1: single clock; all state updates on the rising edge.
REQ-004 Reset_n  input  1: asynchronous, active-low reset.
REQ-005 Din  input  1: serial data bit.
REQ-006 Din_valid  input  1: Din is sampled only when this is high.
REQ-007 Start  input  1: one-cycle pulse that latches Pattern and Overlap and arms detection.
REQ-008 Clear  input  1: synchronous return to IDLE; clears the window and the counter.
REQ-009 Pattern  input  PAT_W: target sequence; the MSB is the first bit received.
REQ-010 Overlap  input  1: 1 = overlapping matches, 0 = non-overlapping matches.
REQ-011 Dout  output  1: registered match pulse.
REQ-012 Match_cnt  output  CNT_W: saturating count of matches.
REQ-013 Armed  output  1: high in FILL or HUNT.

Function
REQ-014 FSM states: IDLE, FILL, HUNT; encoding is one-hot.
REQ-015 IDLE: Start moves to FILL, latches Pattern and Overlap into internal registers, and zeroes the window and the fill count.
REQ-016 FILL: each Din_valid shifts Din into the window LSB and increments the fill count; on reaching PAT_W valid bits, the state moves to HUNT.
REQ-017 HUNT: each Din_valid shifts Din into the window LSB.
REQ-018 Match detection: the window, including the bit being shifted in this cycle, equals the latched pattern with all PAT_W bits valid.
REQ-019 Dout: high for exactly one cycle, in the cycle after the Din_valid that completes a match; latency is 1 cycle.
REQ-020 Overlap=1: after a match, the state stays in HUNT and the window is retained.
REQ-021 Overlap=0: after a match, the state goes to FILL with the fill count zeroed, so the bits of the completed match are not reused.
REQ-022 Din_valid low: the window, fill count, and state hold, and Dout is 0 in the following cycle.
REQ-023 Start outside IDLE is ignored; Pattern and Overlap changes after Start have no effect until the next Start.
REQ-024 Clear wins over Start and Din_valid in the same cycle: next state is IDLE, Match_cnt is 0, and Dout is 0 in the following cycle.
REQ-025 A first-bit match when PAT_W=2 requires two valid bits; there is no partial-window match.
REQ-026 Match_cnt increments by 1 per match and saturates at all-ones, with no wrap.
REQ-027 Armed is driven combinationally from the state register.

Reset
REQ-028 Reset_n low, asynchronously: state IDLE; window, fill count, latched pattern, and Overlap all 0; Dout 0; Match_cnt 0; Armed 0.
REQ-029 Reset asserted mid-sequence discards the partial window; after reset release, no match is reported until a new Start is followed by PAT_W valid bits.

Configuration
REQ-030 Macro SEQ_DETECT_CNT_EN defined: the Match_cnt counter is built per REQ-026.
REQ-031 Macro SEQ_DETECT_CNT_EN undefined: Match_cnt is tied to 0, no counter flops exist, and all other behaviour is unchanged.

Structure
REQ-032 Shared package seq_detect_pkg holds the state enum (IDLE/FILL/HUNT), the one-hot encodings, and the default constants PAT_W_DEF=4 and CNT_W_DEF=8.
REQ-033 One sub-module, seq_window_shift, holds the PAT_W shift register and fill counter with its full flag; the FSM, compare logic, and counter stay in the top module.

Verification
REQ-034 PAT_W=4, Pattern=0111, Overlap=0; Start, then Din=0,1,1,1 all valid -> Dout=1 one cycle after the 4th bit, and Match_cnt=1.
REQ-035 PAT_W=4, Pattern=1010, Overlap=1, stream 1,0,1,0,1,0 -> Dout pulses after bits 4 and 6, and Match_cnt=2; the same stream with Overlap=0 -> a single pulse after bit 4, and Match_cnt=1.
REQ-036 Pattern=0111, bits 0,1 valid, Din_valid low for 3 cycles, then bits 1,1 -> no pulse during the gap, and Dout=1 after the final bit.
REQ-037 Reset_n pulsed low after bits 0,1,1 of pattern 0111 -> all outputs 0 immediately and state IDLE; after reset, bit 1 without a Start -> Dout stays 0.
REQ-038 CNT_W=2, Overlap=1, Pattern=11, stream of 6 valid ones -> 5 Dout pulses and Match_cnt saturates at 3; Clear and Start asserted together -> state IDLE and Match_cnt=0.
REQ-039 Build without SEQ_DETECT_CNT_EN, rerun REQ-034 -> Dout identical and Match_cnt constantly 0.
